// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry, pixel payload type and address helpers.
package vga_pkg;

  localparam int unsigned H_RES     = 160;
  localparam int unsigned V_RES     = 120;
  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned COLOR_W   = 12;
  localparam int unsigned COORD_W   = 8;
  localparam int unsigned LAST_ADDR = H_RES * V_RES - 1;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  // y*H_RES + x; the default 160-wide frame uses (y<<7)+(y<<5) instead of a multiplier.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
    if (H_RES == 160)
      return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
    else
      return ADDR_W'(ADDR_W'(y) * ADDR_W'(H_RES)) + ADDR_W'(x);
  endfunction

  function automatic logic in_range(input pixel_t p);
    return (p.x < COORD_W'(H_RES)) && (p.y < COORD_W'(V_RES));
  endfunction

endpackage

// File: rtl/fb_pixel_writer_pix_fifo.sv
// Small synchronous FIFO of pixel_t entries; DEPTH must be a power of two.
module pix_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_push,
  input  pixel_t i_data,
  input  logic   i_pop,
  output pixel_t o_data,
  output logic   o_full,
  output logic   o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  pixel_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == CNT_W'(0));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Buffers drawer pixel writes, drops off-screen ones and drives the frame-RAM write port.
module fb_pixel_writer
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [7:0]        pix_x,
  input  logic [7:0]        pix_y,
  input  logic [11:0]       pix_color,
  input  logic              fb_busy,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [11:0]       fb_data,
  output logic              frame_done,
  output logic [15:0]       drop_count
);

  pixel_t              w_in;
  pixel_t              w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_complete;
  logic                w_pop;
  logic                w_in_range;

  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [COLOR_W-1:0]  r_data;
  logic                r_frame_done;
  logic [15:0]         r_drop;

  assign w_in      = '{x: pix_x, y: pix_y, color: pix_color};
  assign pix_ready = !w_full;

  pix_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (pix_valid),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The output register refills in the same edge it retires, giving 1 pixel/cycle.
  assign w_complete = r_we && !fb_busy;
  assign w_pop      = !w_empty && (!r_we || w_complete);
  assign w_in_range = in_range(w_head);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_frame_done <= 1'b0;
      r_drop       <= '0;
    end else begin
      r_frame_done <= w_complete && (r_addr == ADDR_W'(LAST_ADDR));
      if (w_pop && w_in_range) begin
        r_we   <= 1'b1;
        r_addr <= lin_addr(w_head.x, w_head.y);
        r_data <= w_head.color;
      end else if (w_complete) begin
        r_we <= 1'b0;
      end
      if (w_pop && !w_in_range && (r_drop != 16'hFFFF))
        r_drop <= r_drop + 16'd1;
    end
  end

  assign fb_we      = r_we;
  assign fb_addr    = r_addr;
  assign fb_data    = r_data;
  assign frame_done = r_frame_done;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer with a write scoreboard and negedge monitor.
module tb_fb_pixel_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic [11:0] pix_color;
  logic        fb_busy;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [11:0] fb_data;
  logic        frame_done;
  logic [15:0] drop_count;

  int          n_cmp = 0;
  int          n_err = 0;
  int          fd_count = 0;
  int          n_writes = 0;
  logic [15:0] exp_drop = '0;
  logic        exp_fd = 1'b0;
  logic        held_v = 1'b0;
  logic [14:0] held_addr;
  logic [11:0] held_data;
  logic [26:0] exp_q [$];

  fb_pixel_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_color  (pix_color),
    .fb_busy    (fb_busy),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .frame_done (frame_done),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one pixel, record its expected effect, and return #1 after the accepting edge.
  task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [11:0] c);
    int n;
    pix_x = x; pix_y = y; pix_color = c; pix_valid = 1'b1;
    if (x < 160 && y < 120) exp_q.push_back({15'(int'(y) * 160 + int'(x)), c});
    else if (exp_drop != 16'hFFFF) exp_drop++;
    n = 0;
    @(negedge clk);
    while (!pix_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!pix_ready) chk("push_ready_timeout", 32'(pix_ready), 32'd1);
    @(posedge clk);
    #1 pix_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fb_we) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_we", 32'(fb_we), 32'd0);
  endtask

  // Scoreboard: every completed write must match the next expected pixel.
  always @(negedge clk) begin
    logic [26:0] e;
    if (!rst_n) begin
      exp_fd = 1'b0;
      held_v = 1'b0;
    end else begin
      if (exp_fd || frame_done) begin
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
        if (frame_done === 1'b1) fd_count++;
      end
      exp_fd = 1'b0;
      if (held_v && fb_we) begin
        chk("hold_addr", 32'(fb_addr), 32'(held_addr));
        chk("hold_data", 32'(fb_data), 32'(held_data));
      end
      held_v    = fb_we && fb_busy;
      held_addr = fb_addr;
      held_data = fb_data;
      if (fb_we && !fb_busy) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(fb_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(fb_addr), 32'(e[26:12]));
          chk("wr_data", 32'(fb_data), 32'(e[11:0]));
          if (e[26:12] == 15'd19199) exp_fd = 1'b1;
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int fd0;
    // 1: reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pix_valid = 1'($urandom); pix_x = 8'($urandom); pix_y = 8'($urandom);
      pix_color = 12'($urandom); fb_busy = 1'($urandom);
      @(negedge clk);
      chk("rst_we", 32'(fb_we), 32'd0);
      chk("rst_addr", 32'(fb_addr), 32'd0);
      chk("rst_data", 32'(fb_data), 32'd0);
      chk("rst_drop", 32'(drop_count), 32'd0);
      chk("rst_fd", 32'(frame_done), 32'd0);
    end
    pix_valid = 1'b0; fb_busy = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(pix_ready), 32'd1);

    // 2: single pixel latency and one-cycle write
    @(posedge clk); #1;
    push(8'd5, 8'd2, 12'hF00);
    @(negedge clk);
    chk("lat_pre_we", 32'(fb_we), 32'd0);
    @(negedge clk);
    chk("lat_we", 32'(fb_we), 32'd1);
    chk("lat_addr", 32'(fb_addr), 32'd325);
    chk("lat_data", 32'(fb_data), 32'hF00);
    @(negedge clk);
    chk("lat_post_we", 32'(fb_we), 32'd0);
    drain();

    // 3: range check at both edges plus the last pixel
    fd0 = fd_count;
    @(posedge clk); #1;
    push(8'd160, 8'd0, 12'h00A);
    push(8'd0, 8'd120, 12'h00B);
    push(8'd159, 8'd119, 12'h0F0);
    drain();
    chk("range_drop", 32'(drop_count), 32'd2);
    chk("range_drop_model", 32'(drop_count), 32'(exp_drop));
    chk("range_fd_count", 32'(fd_count), 32'(fd0 + 1));

    // 4: backpressure; 5 accepted, 6th stalls until fb_busy drops
    @(posedge clk); #1 fb_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(10 + i), 8'd1, 12'(12'h111 * (i + 1)));
    fork
      push(8'd15, 8'd1, 12'h666);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_ready_low", 32'(pix_ready), 32'd0);
          chk("bp_we_held", 32'(fb_we), 32'd1);
          chk("bp_addr_held", 32'(fb_addr), 32'd170);
          chk("bp_data_held", 32'(fb_data), 32'h111);
        end
        @(posedge clk); #1 fb_busy = 1'b0;
        w0 = n_writes;
        repeat (6) begin
          @(negedge clk);
          chk("bp_stream_we", 32'(fb_we), 32'd1);
        end
        @(negedge clk);
        chk("bp_writes", 32'(n_writes - w0), 32'd6);
      end
    join
    drain();

    // 6: reset mid-stream with 3 entries buffered and one pending
    @(posedge clk); #1 fb_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(20 + i), 8'd3, 12'(12'h0A0 + i));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(fb_we), 32'd0);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    exp_q.delete();
    exp_drop = '0;
    fb_busy = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("mid_rst_no_write", 32'(fb_we), 32'd0);
    end
    chk("mid_rst_ready", 32'(pix_ready), 32'd1);

    // 5: drop counter saturation (65537 out-of-range pixels)
    @(posedge clk); #1;
    for (int i = 0; i < 65534; i++) push(8'd200, 8'(i), 12'h000);
    drain();
    chk("sat_fffe", 32'(drop_count), 32'hFFFE);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push(8'd0, 8'd250, 12'h123);
    drain();
    chk("sat_ffff", 32'(drop_count), 32'hFFFF);
    chk("sat_model", 32'(drop_count), 32'(exp_drop));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
